// File: rtl/pipeline_stall_controller_pkg.sv
// Shared pipeline types: stall counter width/limit and the stall controller FSM states.
package pipeline_stall_controller_pkg;

  typedef logic [1:0] stall_count_t;

  localparam stall_count_t MAX_STALL = 2'd3;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DIV_ISSUE = 2'd1,
    DIV_WAIT  = 2'd2
  } pipe_ctrl_state_t;

endpackage

// File: rtl/pipeline_stall_controller_saturating_counter.sv
// Up-counter that sticks at MAX; clear wins over inc, reset wins over both.
module saturating_counter
  import pipeline_stall_controller_pkg::*;
#(
  parameter int unsigned           WIDTH = $bits(stall_count_t),
  parameter logic [WIDTH-1:0]      MAX   = WIDTH'(MAX_STALL)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (reset || clear)
      count_d = '0;
    else if (inc && (count_q != MAX))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline sequencer: folds hazard stalls, divider handshake and EX redirects into
// per-stage enables/flushes, and tracks how long the ID instruction has been held.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       hazard_stall,
  input  logic       ex_is_div,
  input  logic       div_ready,
  output logic       div_start,
  input  logic       div_done,
  input  logic       redirect,
  output logic       pc_enable,
  output logic       if_id_enable,
  output logic       id_ex_enable,
  output logic       ex_mem_enable,
  output logic       mem_wb_enable,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       ex_mem_bubble,
  output logic [1:0] stall_count,
  output logic [1:0] state
);

  pipe_ctrl_state_t state_q, state_d;
  logic             id_advance;

  always_ff @(posedge clock) begin
    state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (reset) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:       if (ex_is_div) state_d = DIV_ISSUE;
        DIV_ISSUE: if (div_ready) state_d = DIV_WAIT;
        DIV_WAIT:  if (div_done)  state_d = RUN;
        default:   state_d = RUN;
      endcase
    end
  end

  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    id_ex_enable  = 1'b1;
    ex_mem_enable = 1'b1;
    mem_wb_enable = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    div_start     = 1'b0;
    if (reset) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_enable = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          // Divide detection outranks everything: the divide must occupy EX first.
          if (ex_is_div) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_bubble = 1'b1;
          end else if (redirect) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (hazard_stall) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        DIV_ISSUE, DIV_WAIT: begin
          div_start = (state_q == DIV_ISSUE);
          if (!(state_q == DIV_WAIT && div_done)) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // A flush counts as advancing: the wrong-path instruction is gone.
  assign id_advance = (id_ex_enable && !id_ex_bubble) || if_id_flush;

  saturating_counter #(
    .WIDTH ($bits(stall_count_t)),
    .MAX   (MAX_STALL)
  ) u_stall_count (
    .clock (clock),
    .reset (reset),
    .inc   (!id_advance),
    .clear (id_advance),
    .count (stall_count)
  );

  assign state = state_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed test-plan steps followed by constrained-random cycles, each checked
// against a behavioural model of the stall rules.
module tb_pipeline_stall_controller;
  import pipeline_stall_controller_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       hazard_stall = 1'b0;
  logic       ex_is_div = 1'b0;
  logic       div_ready = 1'b0;
  logic       div_done = 1'b0;
  logic       redirect = 1'b0;
  logic       div_start;
  logic       pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable;
  logic       if_id_flush, id_ex_bubble, ex_mem_bubble;
  logic [1:0] stall_count;
  logic [1:0] state;

  pipeline_stall_controller dut (
    .clock         (clock),
    .reset         (reset),
    .hazard_stall  (hazard_stall),
    .ex_is_div     (ex_is_div),
    .div_ready     (div_ready),
    .div_start     (div_start),
    .div_done      (div_done),
    .redirect      (redirect),
    .pc_enable     (pc_enable),
    .if_id_enable  (if_id_enable),
    .id_ex_enable  (id_ex_enable),
    .ex_mem_enable (ex_mem_enable),
    .mem_wb_enable (mem_wb_enable),
    .if_id_flush   (if_id_flush),
    .id_ex_bubble  (id_ex_bubble),
    .ex_mem_bubble (ex_mem_bubble),
    .stall_count   (stall_count),
    .state         (state)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: is a divide occupying EX, has its start been accepted, cycles ID has been held.
  bit m_in_div  = 1'b0;
  bit m_started = 1'b0;
  int m_held    = 0;
  int hs_cnt    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input logic r, input logic hz, input logic xd,
                      input logic rdy, input logic dn, input logic rd);
    logic e_pc, e_ifid, e_idex, e_exmem, e_mw, e_fl, e_idb, e_exb, e_ds, adv;
    pipe_ctrl_state_t e_st;
    int e_cnt;
    @(negedge clock);
    reset = r; hazard_stall = hz; ex_is_div = xd;
    div_ready = rdy; div_done = dn; redirect = rd;
    #1;
    e_pc = 1'b1; e_ifid = 1'b1; e_idex = 1'b1; e_exmem = 1'b1; e_mw = 1'b1;
    e_fl = 1'b0; e_idb = 1'b0; e_exb = 1'b0; e_ds = 1'b0;
    if (r) begin
      e_pc = 1'b0; e_ifid = 1'b0; e_idex = 1'b0; e_exmem = 1'b0; e_mw = 1'b0;
      e_fl = 1'b1; e_idb = 1'b1; e_exb = 1'b1;
    end else if (!m_in_div) begin
      if (xd) begin
        e_pc = 1'b0; e_ifid = 1'b0; e_idex = 1'b0; e_exb = 1'b1;
      end else if (rd) begin
        e_fl = 1'b1; e_idb = 1'b1;
      end else if (hz) begin
        e_pc = 1'b0; e_ifid = 1'b0; e_idb = 1'b1;
      end
    end else if (!(m_started && dn)) begin
      e_pc = 1'b0; e_ifid = 1'b0; e_idex = 1'b0; e_exmem = 1'b0;
      e_ds = !m_started;
    end
    e_st  = !m_in_div ? RUN : (m_started ? DIV_WAIT : DIV_ISSUE);
    e_cnt = (m_held > int'(MAX_STALL)) ? int'(MAX_STALL) : m_held;

    chk("pc_enable",     32'(pc_enable),     32'(e_pc));
    chk("if_id_enable",  32'(if_id_enable),  32'(e_ifid));
    chk("id_ex_enable",  32'(id_ex_enable),  32'(e_idex));
    chk("ex_mem_enable", 32'(ex_mem_enable), 32'(e_exmem));
    chk("mem_wb_enable", 32'(mem_wb_enable), 32'(e_mw));
    chk("if_id_flush",   32'(if_id_flush),   32'(e_fl));
    chk("id_ex_bubble",  32'(id_ex_bubble),  32'(e_idb));
    chk("ex_mem_bubble", 32'(ex_mem_bubble), 32'(e_exb));
    chk("div_start",     32'(div_start),     32'(e_ds));
    chk("state",         32'(state),         32'(e_st));
    chk("stall_count",   32'(stall_count),   32'(e_cnt));

    if (!r && div_start && rdy) hs_cnt++;
    if (!r && m_in_div && m_started && dn) begin
      chk("div_handshakes", 32'(hs_cnt), 32'd1);
      hs_cnt = 0;
    end

    adv = (e_idex && !e_idb) || e_fl;
    if (r) begin
      m_in_div = 1'b0; m_started = 1'b0; m_held = 0; hs_cnt = 0;
    end else begin
      m_held = adv ? 0 : m_held + 1;
      if (!m_in_div) begin
        if (xd) begin m_in_div = 1'b1; m_started = 1'b0; end
      end else if (!m_started) begin
        if (rdy) m_started = 1'b1;
      end else if (dn) begin
        m_in_div = 1'b0;
      end
    end
  endtask

  initial begin
    logic r, hz, xd, rdy, dn, rd;
    // step(reset, hazard_stall, ex_is_div, div_ready, div_done, redirect)
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // hazard held four cycles, then released
    repeat (4) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // division: divider busy until t+3, done at t+6
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    // redirect beats hazard and clears the held count
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // hazard during DIV_WAIT: no extra bubble, count saturates, done clears it
    step(0, 0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    repeat (3) step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    // back-to-back divisions
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    // reset for two cycles while waiting on the divider
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // random legal traffic: no redirect with a divide, done only while waiting
    repeat (600) begin
      r   = ($urandom_range(0, 59) == 0);
      hz  = ($urandom_range(0, 2) == 0);
      xd  = m_in_div ? 1'b1 : ($urandom_range(0, 5) == 0);
      rd  = (!xd && !m_in_div) ? ($urandom_range(0, 4) == 0) : 1'b0;
      rdy = $urandom_range(0, 1) == 1;
      dn  = (m_in_div && m_started) ? ($urandom_range(0, 2) == 0) : 1'b0;
      step(r, hz, xd, rdy, dn, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
